// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the single VGA framebuffer write port shared by N draw engines.
// Optional watchdog (define DRAW_ARB_WATCHDOG_EN) force-releases a grant after TIMEOUT cycles.
module draw_port_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned COLOR_W = 3,
    parameter int unsigned TIMEOUT = 16384
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           done,
    input  logic [N_REQ*X_W-1:0]       px_x,
    input  logic [N_REQ*Y_W-1:0]       px_y,
    input  logic [N_REQ*COLOR_W-1:0]   px_colour,
    input  logic [N_REQ-1:0]           px_plot,
    output logic [N_REQ-1:0]           grant,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COLOR_W-1:0]         vga_colour,
    output logic                       vga_plot,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
        $error("draw_port_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StActive, StRelease} state_e;

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COLOR_W-1:0]   vga_colour_q, vga_colour_d;
    logic                 vga_plot_q, vga_plot_d;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand_idx;
    int unsigned          cand;

    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOR_W-1:0]   sel_colour;
    logic                 sel_plot;
    logic                 sel_done;
    logic                 sel_req;

    // Search upward from the engine after the last owner, wrapping round.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand     = (32'(last_q) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_done   = 1'b0;
        sel_req    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                sel_x      = px_x[i*X_W +: X_W];
                sel_y      = px_y[i*Y_W +: Y_W];
                sel_colour = px_colour[i*COLOR_W +: COLOR_W];
                sel_plot   = px_plot[i];
                sel_done   = done[i];
                sel_req    = req[i];
            end
        end
    end

`ifdef DRAW_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wdog_cnt_q;
    logic             wdog_fire;
    logic             timeout_err_q;

    assign wdog_fire = (wdog_cnt_q == CNT_W'(TIMEOUT - 1));

    // Counter sits at zero outside ACTIVE, so it is cleared on every ACTIVE entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_cnt_q    <= (state_q == StActive) ? wdog_cnt_q + 1'b1 : '0;
            timeout_err_q <= (state_q == StActive) && wdog_fire && !sel_done;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_d       = last_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d           = StActive;
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            StActive: begin
                // The pixel of the terminal cycle is still forwarded.
                vga_x_d      = sel_x;
                vga_y_d      = sel_y;
                vga_colour_d = sel_colour;
                vga_plot_d   = sel_plot;
                if (sel_done || !sel_req) begin
                    state_d = StRelease;
                    grant_d = '0;
                end
`ifdef DRAW_ARB_WATCHDOG_EN
                else if (wdog_fire) begin
                    state_d = StRelease;
                    grant_d = '0;
                end
`endif
            end
            StRelease: begin
                state_d = StIdle;
                last_d  = gidx_q;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_q       <= IDX_W'(N_REQ - 1);
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_q       <= last_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign grant      = grant_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Self-checking bench for draw_port_arbiter: arbitration vector table plus pixel scoreboard.
// Watchdog sequence is compiled in when DRAW_ARB_WATCHDOG_EN is defined.
module tb_draw_port_arbiter;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      done;
    logic [N*XW-1:0]   px_x;
    logic [N*YW-1:0]   px_y;
    logic [N*CW-1:0]   px_colour;
    logic [N-1:0]      px_plot;
    logic [N-1:0]      grant;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_colour;
    logic              vga_plot;
    logic              busy;
    logic              timeout_err;

    draw_port_arbiter #(
        .N_REQ   (N),
        .X_W     (XW),
        .Y_W     (YW),
        .COLOR_W (CW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_colour   (px_colour),
        .px_plot     (px_plot),
        .grant       (grant),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic         busy;
    } vec_t;

    vec_t vecs[8];

    logic [XW+YW+CW-1:0] sb[$];
    int checks = 0;
    int errors = 0;
    int plots  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the edge and plots are scoreboarded.
    task automatic cyc();
        logic [XW+YW+CW-1:0] exp;
        @(posedge clk);
        #1;
        if (vga_plot === 1'b1) begin
            plots++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_plot: got pixel %0h expected no plot",
                         {vga_x, vga_y, vga_colour});
            end else begin
                exp = sb.pop_front();
                chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp));
            end
        end
    endtask

    task automatic set_px(input int e, input logic [XW-1:0] x, input logic [YW-1:0] y,
                          input logic [CW-1:0] c, input logic pl, input bit fwd);
        px_x[e*XW +: XW]      = x;
        px_y[e*YW +: YW]      = y;
        px_colour[e*CW +: CW] = c;
        px_plot[e]            = pl;
        if (pl && fwd) sb.push_back({x, y, c});
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = '0;
        done      = '0;
        px_x      = '0;
        px_y      = '0;
        px_colour = '0;
        px_plot   = '0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] order[5];
        int           gap;
        bit           held;

        vecs[0] = '{req: 4'b0000, grant: 4'b0000, busy: 1'b0};
        vecs[1] = '{req: 4'b0001, grant: 4'b0001, busy: 1'b1};
        vecs[2] = '{req: 4'b0010, grant: 4'b0010, busy: 1'b1};
        vecs[3] = '{req: 4'b1100, grant: 4'b0100, busy: 1'b1};
        vecs[4] = '{req: 4'b1010, grant: 4'b0010, busy: 1'b1};
        vecs[5] = '{req: 4'b1111, grant: 4'b0001, busy: 1'b1};
        vecs[6] = '{req: 4'b1000, grant: 4'b1000, busy: 1'b1};
        vecs[7] = '{req: 4'b0110, grant: 4'b0010, busy: 1'b1};
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        do_reset();
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 0);
        chk("rst_tmo", 32'(timeout_err), 0);

        // First arbitration from reset (engine 0 highest priority)
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req = vecs[i].req;
            cyc();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
        end

        // 1: single engine, five pixels, done on the fifth
        do_reset();
        plots = 0;
        req = 4'b0001;
        cyc();
        chk("t1_grant", 32'(grant), 32'(4'b0001));
        for (int i = 0; i < 5; i++) begin
            set_px(0, XW'(10 + i), 7'd20, 3'd3, 1'b1, 1'b1);
            done = (i == 4) ? 4'b0001 : 4'b0000;
            cyc();
        end
        chk("t1_rel_grant", 32'(grant), 0);
        chk("t1_rel_busy", 32'(busy), 1);
        set_px(0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        done = '0;
        req  = '0;
        cyc();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_plot", 32'(vga_plot), 0);
        chk("t1_hold_x", 32'(vga_x), 14);
        chk("t1_plots", 32'(plots), 5);

        // 2: all requesting, round-robin with two dead cycles between grants
        do_reset();
        req = 4'b1111;
        cyc();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                gap = 0;
                while (grant == '0 && gap < 6) begin
                    cyc();
                    gap++;
                end
                chk($sformatf("t2_gap%0d", k), 32'(gap), 2);
            end
            chk($sformatf("t2_order%0d", k), 32'(grant), 32'(order[k]));
            cyc();
            cyc();
            done = order[k];
            cyc();
            done = '0;
        end
        req = '0;
        cyc();
        cyc();

        // 3: non-granted engine's done/plot are ignored
        do_reset();
        req = 4'b0010;
        cyc();
        chk("t3_grant", 32'(grant), 32'(4'b0010));
        req = 4'b0110;
        set_px(1, 8'd50, 7'd60, 3'd5, 1'b1, 1'b1);
        set_px(2, 8'd99, 7'd99, 3'd7, 1'b1, 1'b0);
        done = 4'b0100;
        cyc();
        chk("t3_grant_kept", 32'(grant), 32'(4'b0010));
        set_px(1, 8'd50, 7'd60, 3'd5, 1'b0, 1'b0);
        done = '0;
        cyc();
        chk("t3_no_foreign_plot", 32'(vga_plot), 0);
        chk("t3_grant_kept2", 32'(grant), 32'(4'b0010));
        set_px(2, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        done = 4'b0010;
        cyc();
        done = '0;
        req  = '0;
        cyc();
        cyc();

        // 4: abort by dropping req; last becomes 3 so engine 0 wins over 1 and 2
        do_reset();
        req = 4'b0010;
        cyc();
        done = 4'b0010;
        cyc();
        done = '0;
        req  = 4'b1000;
        cyc();
        cyc();
        chk("t4_grant3", 32'(grant), 32'(4'b1000));
        req = 4'b0111;
        cyc();
        chk("t4_abort_grant", 32'(grant), 0);
        chk("t4_abort_busy", 32'(busy), 1);
        cyc();
        chk("t4_idle_grant", 32'(grant), 0);
        cyc();
        chk("t4_next_grant", 32'(grant), 32'(4'b0001));
        req = '0;
        cyc();
        cyc();

        // 5: reset in the middle of a draw
        do_reset();
        req = 4'b0100;
        cyc();
        chk("t5_grant", 32'(grant), 32'(4'b0100));
        set_px(2, 8'd33, 7'd44, 3'd6, 1'b1, 1'b1);
        cyc();
        chk("t5_sb_drained", 32'(sb.size()), 0);
        reset = 1'b0;
        req   = 4'b1111;
        set_px(2, 8'd77, 7'd11, 3'd2, 1'b1, 1'b0);
        cyc();
        chk("t5_rst_grant", 32'(grant), 0);
        chk("t5_rst_plot", 32'(vga_plot), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_x", 32'(vga_x), 0);
        reset = 1'b1;
        set_px(2, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0);
        cyc();
        chk("t5_regrant", 32'(grant), 32'(4'b0001));

`ifdef DRAW_ARB_WATCHDOG_EN
        // 6: watchdog release after 8 ACTIVE cycles, then done in the terminal cycle
        do_reset();
        req = 4'b0100;
        cyc();
        chk("t6_grant", 32'(grant), 32'(4'b0100));
        held = 1'b1;
        for (int i = 1; i < 8; i++) begin
            cyc();
            if (grant != 4'b0100 || timeout_err != 1'b0) held = 1'b0;
        end
        chk("t6_held7", 32'(held), 1);
        cyc();
        chk("t6_tmo_grant", 32'(grant), 0);
        chk("t6_tmo_err", 32'(timeout_err), 1);
        cyc();
        chk("t6_tmo_pulse", 32'(timeout_err), 0);
        cyc();
        chk("t6_regrant", 32'(grant), 32'(4'b0100));
        for (int i = 1; i < 8; i++) cyc();
        done = 4'b0100;
        cyc();
        done = '0;
        req  = '0;
        chk("t6_done_grant", 32'(grant), 0);
        chk("t6_done_no_err", 32'(timeout_err), 0);
        cyc();
        cyc();
`else
        // 6: without the watchdog a grant is held indefinitely
        do_reset();
        req = 4'b0100;
        cyc();
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (grant != 4'b0100 || timeout_err != 1'b0) held = 1'b0;
        end
        chk("t6_held", 32'(held), 1);
        chk("t6_no_err", 32'(timeout_err), 0);
        req = '0;
        cyc();
        cyc();
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
